tick_divider: RTL and testbench

Downstream consumer of the single-cycle `result` tick stream produced by the start-triggered phase sequencer. It divides the ticks by a configurable ratio and turns every DIV-th tick into an indexed event. Events are queued as a pending count and presented on a valid/ready output toward the scheduler. All state is registered on one clock, and all registers share the sequencer's `en` gating.

---
 rtl/tick_divider.sv | 128 ++++++++++++
 tb/tb_tick_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//
// Divides a stream of single-cycle ticks by DIV. Every DIV-th accepted tick
// generates an event carrying a sequential index. Events wait in a pending
// counter and are presented on a valid/ready output, oldest index first.
//
// Parameters
//   DIV     ticks per generated event (>= 2)
//   CNT_W   width of the event index (wraps modulo 2^CNT_W)
//   PEND_W  width of the pending counter (max pending = 2^PEND_W - 1)
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (overrides en)
//   en         in   clock enable; 0 freezes every register
//   tick       in   single-cycle tick from the upstream sequencer
//   out_valid  out  at least one event pending (registered)
//   out_ready  in   consumer accepts the presented event
//   out_idx    out  index of the oldest pending event
//   phase      out  tick count within the current divide period
//   ovf        out  sticky "event dropped" flag
//
// Optional feature (macro TICK_DIV_OVF_EN)
//   defined     : ovf is a sticky register set on any dropped event,
//                 cleared only by rst.
//   not defined : ovf is tied to 0; drops still happen silently.
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter  int DIV    = 4,
  parameter  int CNT_W  = 8,
  parameter  int PEND_W = 2,
  localparam int PH_W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_idx,
  output logic [PH_W-1:0]  phase,
  output logic             ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DIV - 1);

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic [CNT_W-1:0]  head_q,  head_d;

  logic accept;  // tick taken this cycle
  logic gen;     // tick closes a divide period -> new event
  logic pop;     // consumer takes the oldest event
  logic full;    // pending counter at its maximum

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    phase_d = phase_q;
    pend_d  = pend_q;
    head_d  = head_q;

    // en gates both request sources, so holding state when en=0 falls out
    // of the next-state logic without a separate hold branch.
    accept = en & tick;
    gen    = accept & (phase_q == PH_LAST);
    pop    = en & (pend_q != '0) & out_ready;
    full   = (pend_q == PEND_MAX);

    if (accept) begin
      phase_d = gen ? '0 : phase_q + 1'b1;
    end

    if (pop) begin
      head_d = head_q + 1'b1;
    end

    // A simultaneous generate and pop leaves the count unchanged even when
    // full: the slot freed by the pop absorbs the new event. A generate
    // without pop while full is dropped, leaving head and count untouched so
    // the index sequence carries on without a gap.
    if (gen && !pop && !full) begin
      pend_d = pend_q + 1'b1;
    end else if (pop && !gen) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      phase_q <= '0;
      pend_q  <= '0;
      head_q  <= '0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
    end
  end

  assign out_valid = (pend_q != '0);
  assign out_idx   = head_q;
  assign phase     = phase_q;

`ifdef TICK_DIV_OVF_EN
  logic drop;
  logic ovf_q;

  assign drop = gen & ~pop & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_tick_divider.sv
// -----------------------------------------------------------------------------
// tb_tick_divider
//
// Drives two tick_divider instances (CNT_W=8 and CNT_W=2) with identical
// stimulus. A queue-based model of pending event indices predicts every
// output; a compare process checks both DUTs against it on each falling edge.
// Directed scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_divider;

  localparam int DIV     = 4;
  localparam int PEND_W  = 2;
  localparam int MAX_PEN = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst, en, tick, out_ready;

  logic       v8, v2, ovf8, ovf2;
  logic [7:0] idx8;
  logic [1:0] idx2;
  logic [1:0] ph8, ph2;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  tick_divider #(.DIV(DIV), .CNT_W(8), .PEND_W(PEND_W)) dut8 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .out_valid(v8), .out_ready(out_ready), .out_idx(idx8),
    .phase(ph8), .ovf(ovf8)
  );

  tick_divider #(.DIV(DIV), .CNT_W(2), .PEND_W(PEND_W)) dut2 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .out_valid(v2), .out_ready(out_ready), .out_idx(idx2),
    .phase(ph2), .ovf(ovf2)
  );

  // ---------------- behavioural model ----------------
  int q[$];          // indices of stored events, oldest first
  int next_idx = 0;  // index the next stored event will take
  int tick_cnt = 0;  // ticks accepted since reset
  bit m_ovf    = 1'b0;

  always @(posedge clk) begin
    bit do_pop, do_gen;
    if (rst) begin
      q.delete();
      next_idx = 0;
      tick_cnt = 0;
      m_ovf    = 1'b0;
    end else if (en) begin
      do_pop = (q.size() != 0) && out_ready;
      do_gen = tick && ((tick_cnt % DIV) == DIV - 1);
      if (tick) tick_cnt++;
      if (do_pop) void'(q.pop_front());
      if (do_gen) begin
        if (q.size() < MAX_PEN) begin
          q.push_back(next_idx);
          next_idx++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int exp_idx;
    bit exp_ovf;
    if (cmp_on) begin
      exp_idx = (q.size() != 0) ? q[0] : next_idx;
`ifdef TICK_DIV_OVF_EN
      exp_ovf = m_ovf;
`else
      exp_ovf = 1'b0;
`endif
      check("model_valid8", {31'b0, v8},   {31'b0, q.size() != 0});
      check("model_valid2", {31'b0, v2},   {31'b0, q.size() != 0});
      check("model_idx8",   {24'b0, idx8}, exp_idx % 256);
      check("model_idx2",   {30'b0, idx2}, exp_idx % 4);
      check("model_phase8", {30'b0, ph8},  tick_cnt % DIV);
      check("model_phase2", {30'b0, ph2},  tick_cnt % DIV);
      check("model_ovf8",   {31'b0, ovf8}, {31'b0, exp_ovf});
      check("model_ovf2",   {31'b0, ovf2}, {31'b0, exp_ovf});
    end
  end

  // Apply inputs, then return at the falling edge after the next rising edge.
  task automatic cycle(input logic t, input logic r, input logic e, input logic s = 1'b0);
    tick      = t;
    out_ready = r;
    en        = e;
    rst       = s;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  bit ovf_on;

  initial begin
`ifdef TICK_DIV_OVF_EN
    ovf_on = 1'b1;
`else
    ovf_on = 1'b0;
`endif
    rst = 1'b1; en = 1'b0; tick = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    cycle(0, 0, 1, 1);
    cmp_on = 1'b1;
    cycle(0, 0, 1);
    lit("reset_valid", {31'b0, v8},   0);
    lit("reset_idx",   {24'b0, idx8}, 0);
    lit("reset_phase", {30'b0, ph8},  0);
    lit("reset_ovf",   {31'b0, ovf8}, 0);

    // Case 1: four ticks spaced 4 cycles, consumer ready.
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 1, 1);
      lit("c1_phase", {30'b0, ph8}, k % 4);
      if (k == 4) begin
        lit("c1_valid_hi", {31'b0, v8},   1);
        lit("c1_idx0",     {24'b0, idx8}, 0);
      end
      for (int j = 0; j < 3; j++) begin
        cycle(0, 1, 1);
        if (k == 4 && j == 0) begin
          lit("c1_valid_lo", {31'b0, v8},   0);
          lit("c1_idx1",     {24'b0, idx8}, 1);
        end
      end
    end

    // Case 2: fresh reset, 16 ticks with no consumer -> saturate and drop.
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 16; k++) cycle(1, 0, 1);
    lit("c2_valid", {31'b0, v8},   1);
    lit("c2_idx",   {24'b0, idx8}, 0);
    lit("c2_ovf",   {31'b0, ovf8}, {31'b0, ovf_on});

    // Case 3: drain for 4 cycles; next event takes index 3.
    cycle(0, 1, 1); lit("c3_idx1", {24'b0, idx8}, 1);
    cycle(0, 1, 1); lit("c3_idx2", {24'b0, idx8}, 2);
    cycle(0, 1, 1); lit("c3_empty", {31'b0, v8}, 0);
    cycle(0, 1, 1); lit("c3_empty_idx", {24'b0, idx8}, 3);
    for (int k = 0; k < 4; k++) cycle(1, 0, 1);
    lit("c3_next_valid", {31'b0, v8},   1);
    lit("c3_next_idx",   {24'b0, idx8}, 3);

    // Case 4: full, then generate and pop in the same cycle.
    for (int k = 0; k < 11; k++) cycle(1, 0, 1);
    lit("c4_phase3", {30'b0, ph8}, 3);
    cycle(1, 1, 1);
    lit("c4_valid", {31'b0, v8},   1);
    lit("c4_idx",   {24'b0, idx8}, 4);
    lit("c4_ovf",   {31'b0, ovf8}, {31'b0, ovf_on});
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    lit("c4_still_valid", {31'b0, v8}, 1);
    cycle(0, 1, 1);
    lit("c4_drained", {31'b0, v8},   0);
    lit("c4_idx7",    {24'b0, idx8}, 7);

    // Case 5: two pending, phase 3, then en=0 with activity, then reset.
    for (int k = 0; k < 11; k++) cycle(1, 0, 1);
    for (int k = 0; k < 6; k++) begin
      cycle(1, 1, 0);
      lit("c5_frozen_phase", {30'b0, ph8},  3);
      lit("c5_frozen_valid", {31'b0, v8},   1);
      lit("c5_frozen_idx",   {24'b0, idx8}, 7);
    end
    cycle(1, 1, 0, 1);
    lit("c5_rst_valid", {31'b0, v8},   0);
    lit("c5_rst_idx",   {24'b0, idx8}, 0);
    lit("c5_rst_phase", {30'b0, ph8},  0);
    lit("c5_rst_ovf",   {31'b0, ovf8}, 0);

    // Case 6: 2-bit index wraps 0,1,2,3,0.
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < 4; k++) cycle(1, 1, 1);
      lit("c6_valid2", {31'b0, v2},   1);
      lit("c6_idx2",   {30'b0, idx2}, e % 4);
    end

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 85,
            $urandom_range(0, 299) == 0);
    end

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
